// File: rtl/serial_rx_fifo_pkg.sv
// serial_rx_fifo_pkg
// Shared definitions for the serial receive block: deframer state encoding,
// the default bit period, the byte type and the IOCON register offsets.
// No ports (package).
package serial_rx_fifo_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  // FCLK cycles per bit period when nothing overrides it
  localparam logic [7:0] DEFAULT_WAIT_CNT = 8'd70;

  // IOCON register offsets: data pops the head byte, status reads
  // {COUNT, FULL, EMPTY, OVR, FERR}, a write to err-clear drops both flags
  localparam logic [3:0] RX_ADDR_DATA    = 4'h0;
  localparam logic [3:0] RX_ADDR_STATUS  = 4'h4;
  localparam logic [3:0] RX_ADDR_ERR_CLR = 4'h8;

endpackage

// File: rtl/serial_rx_fifo_if.sv
// serial_rx_fifo_if
// Read-side bus between the receive FIFO and the IOCON decoder.
//   RE      read strobe (pop head when not empty)
//   CLR_ERR clear sticky FERR/OVR
//   DOUT    show-ahead head byte, 8'h00 when empty
//   EMPTY, FULL, COUNT  FIFO status
//   FERR, OVR           sticky error flags
// master: the core/IOCON side; slave: the receiver.
interface serial_rx_fifo_if #(parameter int DEPTH_LOG2 = 4);
  import serial_rx_fifo_pkg::*;

  logic                RE;
  logic                CLR_ERR;
  byte_t               DOUT;
  logic                EMPTY;
  logic                FULL;
  logic [DEPTH_LOG2:0] COUNT;
  logic                FERR;
  logic                OVR;

  modport master (
    output RE, CLR_ERR,
    input  DOUT, EMPTY, FULL, COUNT, FERR, OVR
  );

  modport slave (
    input  RE, CLR_ERR,
    output DOUT, EMPTY, FULL, COUNT, FERR, OVR
  );
endinterface

// File: rtl/serial_rx_fifo_fifo.sv
// rx_fifo
// Synchronous circular FIFO with show-ahead output.
//   CLK, RST   clock, async active-high reset (pointers only)
//   push       write push_data when there is room (a same-cycle pop makes room)
//   pop        advance head when not empty
//   dout       head entry, 0 when empty
//   empty, full, count  occupancy status
module rx_fifo
  import serial_rx_fifo_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  byte_t         push_data,
  input  logic          pop,
  output byte_t         dout,
  output logic          empty,
  output logic          full,
  output logic [ADDR_W:0] count
);

  localparam int DEPTH = 1 << ADDR_W;

  byte_t           mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            pop_ok;
  logic            push_ok;

  // Pointers carry one extra wrap bit: equal means empty, equal address
  // with differing wrap bit means full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr[ADDR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo
// 8N1 serial receiver feeding a show-ahead receive FIFO.
//   CLK  system clock (FCLK)
//   RST  async active-high reset
//   RXD  serial line, asynchronous, idle high
//   bus  read port (RE, CLR_ERR in; DOUT, EMPTY, FULL, COUNT, FERR, OVR out)
// WAIT_CNT is the bit period in CLK cycles (>= 4, even).
module serial_rx_fifo
  import serial_rx_fifo_pkg::*;
#(
  parameter logic [7:0] WAIT_CNT   = DEFAULT_WAIT_CNT,
  parameter int         DEPTH_LOG2 = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic RXD,
  serial_rx_fifo_if.slave bus
);

  localparam int          TW        = $clog2(WAIT_CNT);
  localparam logic [TW-1:0] FULL_LAST = TW'(WAIT_CNT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(WAIT_CNT / 2 - 1);

  logic          rx_meta;
  logic          rxs;
  logic          rxs_prev;
  rx_state_t     state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  byte_t         shreg;
  logic          ferr;
  logic          ovr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          expire;
  logic          pop_req;
  logic          stop_event;
  logic          push_req;
  logic          ovr_set;
  logic          ferr_set;

  // Two-flop synchronizer plus one history flop; a start is a falling edge
  // of rxs, so a line held low after a bad stop bit does not rearm.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      rx_meta  <= RXD;
      rxs      <= rx_meta;
      rxs_prev <= rxs;
    end
  end

  // START waits half a bit to land mid start bit; other states wait a full bit
  assign expire     = (state == RX_START) ? (timer == HALF_LAST) : (timer == FULL_LAST);
  assign pop_req    = bus.RE && !fifo_empty;
  assign stop_event = (state == RX_STOP) && expire;
  // The push is decided at the stop-sample edge itself so the byte is
  // visible one cycle later; a simultaneous pop frees a slot when full.
  assign push_req   = stop_event && rxs && (!fifo_full || pop_req);
  assign ovr_set    = stop_event && rxs && fifo_full && !pop_req;
  assign ferr_set   = stop_event && !rxs;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= RX_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ferr    <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      // A set in the same cycle as a clear must win
      if (ferr_set)         ferr <= 1'b1;
      else if (bus.CLR_ERR) ferr <= 1'b0;
      if (ovr_set)          ovr  <= 1'b1;
      else if (bus.CLR_ERR) ovr  <= 1'b0;

      case (state)
        RX_IDLE: begin
          timer <= '0;
          if (rxs_prev && !rxs) state <= RX_START;
        end
        RX_START: begin
          if (expire) begin
            timer   <= '0;
            bit_idx <= '0;
            state   <= rxs ? RX_IDLE : RX_DATA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_DATA: begin
          if (expire) begin
            timer          <= '0;
            shreg[bit_idx] <= rxs;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RX_STOP: begin
          if (expire) begin
            timer <= '0;
            state <= RX_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign bus.FERR = ferr;
  assign bus.OVR  = ovr;

  rx_fifo #(.ADDR_W(DEPTH_LOG2)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_req),
    .push_data (shreg),
    .pop       (bus.RE),
    .dout      (bus.DOUT),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (bus.COUNT)
  );

  assign bus.EMPTY = fifo_empty;
  assign bus.FULL  = fifo_full;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// tb_serial_rx_fifo
// Self-checking bench for serial_rx_fifo with WAIT_CNT=8, depth 16.
// A queue-based model predicts FIFO contents and flags from the frame
// schedule; a compare process checks every output on every cycle.
module tb_serial_rx_fifo;
  import serial_rx_fifo_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 16;

  typedef struct {
    int unsigned edge_no;
    byte_t       data;
    logic        stop;
  } frame_ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_e0 = 0;
  byte_t       model_q[$];
  frame_ev_t   pend[$];
  logic        model_ferr = 1'b0;
  logic        model_ovr  = 1'b0;
  bit          rand_done = 1'b0;

  serial_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  serial_rx_fifo #(.WAIT_CNT(8'd8), .DEPTH_LOG2(4)) dut (
    .CLK (clk),
    .RST (rst),
    .RXD (rxd),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one 8N1 frame starting at the next falling clock edge. The byte
  // is sampled mid stop bit: 2 sync cycles + W/2 + 9*W after the first
  // rising edge that sees RXD low.
  task automatic applyStimulus(input byte_t data, input logic stop_bit);
    frame_ev_t ev;
    @(negedge clk);
    last_e0    = cyc + 1;
    ev.edge_no = last_e0 + 2 + W / 2 + 9 * W;
    ev.data    = data;
    ev.stop    = stop_bit;
    pend.push_back(ev);
    rxd = 1'b0;
    repeat (W) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (W) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (W) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic read_byte(output byte_t b);
    @(negedge clk);
    b = bus.DOUT;
    bus.RE = 1'b1;
    @(negedge clk);
    bus.RE = 1'b0;
  endtask

  task automatic clear_errors;
    @(negedge clk);
    bus.CLR_ERR = 1'b1;
    @(negedge clk);
    bus.CLR_ERR = 1'b0;
  endtask

  // Ends 2 time units after the rising edge numbered n
  task automatic wait_cycle(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    model_q.delete();
    pend.delete();
    model_ferr = 1'b0;
    model_ovr  = 1'b0;
    #1;
    checkOutput("rst_empty", bus.EMPTY, 1);
    checkOutput("rst_full",  bus.FULL,  0);
    checkOutput("rst_count", bus.COUNT, 0);
    checkOutput("rst_dout",  bus.DOUT,  8'h00);
    checkOutput("rst_ferr",  bus.FERR,  0);
    checkOutput("rst_ovr",   bus.OVR,   0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Reference model: FIFO as a queue, updated at each rising edge from the
  // read strobe, the error clear and the scheduled stop-sample events.
  initial begin : model
    frame_ev_t ev;
    bit        do_pop;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        do_pop = bus.RE && (model_q.size() > 0);
        if (bus.CLR_ERR) begin
          model_ferr = 1'b0;
          model_ovr  = 1'b0;
        end
        if (do_pop) void'(model_q.pop_front());
        if (pend.size() > 0 && pend[0].edge_no == cyc) begin
          ev = pend.pop_front();
          if (!ev.stop)                  model_ferr = 1'b1;
          else if (model_q.size() < DEPTH) model_q.push_back(ev.data);
          else                           model_ovr  = 1'b1;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(posedge clk);
      #2;
      checkOutput("cmp_dout",  bus.DOUT,  (model_q.size() > 0) ? 32'(model_q[0]) : 32'h0);
      checkOutput("cmp_empty", bus.EMPTY, 32'(model_q.size() == 0));
      checkOutput("cmp_full",  bus.FULL,  32'(model_q.size() == DEPTH));
      checkOutput("cmp_count", bus.COUNT, 32'(model_q.size()));
      checkOutput("cmp_ferr",  bus.FERR,  32'(model_ferr));
      checkOutput("cmp_ovr",   bus.OVR,   32'(model_ovr));
    end
  end

  initial begin : watchdog
    #3000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    byte_t       b;
    int unsigned e;
    bus.RE      = 1'b0;
    bus.CLR_ERR = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_reset();

    // Single frame: EMPTY falls exactly one cycle after the stop sample
    fork
      applyStimulus(8'hA5, 1'b1);
      begin
        @(negedge clk);
        #1;
        e = last_e0;
        wait_cycle(e + 77);
        checkOutput("a5_empty_before", bus.EMPTY, 1);
        wait_cycle(e + 78);
        checkOutput("a5_empty_after", bus.EMPTY, 0);
        checkOutput("a5_dout",        bus.DOUT,  8'hA5);
        checkOutput("a5_count",       bus.COUNT, 1);
      end
    join
    read_byte(b);
    checkOutput("a5_read", b, 8'hA5);
    #1;
    checkOutput("a5_empty_post", bus.EMPTY, 1);
    checkOutput("a5_dout_post",  bus.DOUT,  8'h00);

    // Short glitch on the line is a false start
    @(negedge clk);
    rxd = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_count", bus.COUNT, 0);
    checkOutput("glitch_ferr",  bus.FERR,  0);
    checkOutput("glitch_ovr",   bus.OVR,   0);

    // Bad stop bit, sticky until cleared, then a clean frame
    applyStimulus(8'h3C, 1'b0);
    checkOutput("ferr_set",   bus.FERR,  1);
    checkOutput("ferr_count", bus.COUNT, 0);
    repeat (20) @(negedge clk);
    checkOutput("ferr_hold", bus.FERR, 1);
    clear_errors();
    checkOutput("ferr_clr", bus.FERR, 0);
    applyStimulus(8'h55, 1'b1);
    read_byte(b);
    checkOutput("after_ferr_read", b, 8'h55);

    // Overrun: 17 frames with no reads
    for (int i = 0; i < 17; i++) applyStimulus(byte_t'(i), 1'b1);
    checkOutput("ovr_count", bus.COUNT, 16);
    checkOutput("ovr_full",  bus.FULL,  1);
    checkOutput("ovr_flag",  bus.OVR,   1);
    for (int i = 0; i < 16; i++) begin
      read_byte(b);
      checkOutput("ovr_order", b, i);
    end
    clear_errors();

    // Full FIFO with a pop in the same cycle as a push
    for (int i = 0; i < 16; i++) applyStimulus(byte_t'(8'h20 + i), 1'b1);
    fork
      applyStimulus(8'h77, 1'b1);
      begin
        @(negedge clk);
        #1;
        e = last_e0;
        wait_cycle(e + 77);
        @(negedge clk);
        bus.RE = 1'b1;
        @(negedge clk);
        bus.RE = 1'b0;
      end
    join
    checkOutput("fullpop_count", bus.COUNT, 16);
    checkOutput("fullpop_ovr",   bus.OVR,   0);
    for (int i = 1; i < 16; i++) begin
      read_byte(b);
      checkOutput("fullpop_order", b, 8'h20 + i);
    end
    read_byte(b);
    checkOutput("fullpop_last", b, 8'h77);

    // Reset mid-frame with data buffered and an error flagged
    applyStimulus(8'h3C, 1'b0);
    applyStimulus(8'h11, 1'b1);
    @(negedge clk);
    rxd = 1'b0;
    repeat (W) @(negedge clk);
    rxd = 1'b1;
    repeat (W) @(negedge clk);
    rxd = 1'b0;
    repeat (W / 2) @(negedge clk);
    do_reset();
    applyStimulus(8'h42, 1'b1);
    read_byte(b);
    checkOutput("post_rst_read", b, 8'h42);

    // Randomized traffic with concurrent random reads and error clears
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          applyStimulus(byte_t'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
          repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clk);
          bus.RE      = ($urandom_range(0, 5) == 0);
          bus.CLR_ERR = ($urandom_range(0, 60) == 0);
        end
        bus.RE      = 1'b0;
        bus.CLR_ERR = 1'b0;
      end
    join
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
